// File: rtl/execute_pkg.sv
// Shared definitions for the execute slice: ALU opcodes, control-word
// bit positions and forwarding-mux select codes.
package execute_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_MUL    = 4'd8,
        ALU_PASS_A = 4'd9,
        ALU_PASS_B = 4'd10,
        ALU_SLT    = 4'd11
    } alu_op_e;

    // Control word produced by decode; an all-zero word is a bubble.
    localparam int CTRL_WRE       = 0;
    localparam int CTRL_WMEM      = 1;
    localparam int CTRL_SEL_WB_LO = 2;
    localparam int CTRL_SEL_WB_HI = 3;
    localparam int CTRL_ALUOP_LO  = 4;
    localparam int CTRL_ALUOP_HI  = 7;
    localparam int CTRL_LOAD      = 8;

    // Forwarding-mux select codes; any other code falls back to the register value.
    localparam logic [2:0] FWD_REG = 3'd0;
    localparam logic [2:0] FWD_WB  = 3'd1;
    localparam logic [2:0] FWD_MEM = 3'd2;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU of the execute stage. Results are truncated to DATA_W;
// undefined opcodes produce zero.
module alu
    import execute_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_e           alu_op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [DATA_W-1:0] result
);

    logic [3:0] shamt;
    logic       less_signed;

    assign shamt       = src_b[3:0];
    assign less_signed = ($signed(src_a) < $signed(src_b));

    // Select the operation result; opcodes 12-15 fall through to zero.
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:    result = src_a + src_b;
            ALU_SUB:    result = src_a - src_b;
            ALU_AND:    result = src_a & src_b;
            ALU_OR:     result = src_a | src_b;
            ALU_XOR:    result = src_a ^ src_b;
            ALU_SLL:    result = src_a << shamt;
            ALU_SRL:    result = src_a >> shamt;
            ALU_SRA:    result = $unsigned($signed(src_a) >>> shamt);
            ALU_MUL:    result = src_a * src_b;
            ALU_PASS_A: result = src_a;
            ALU_PASS_B: result = src_b;
            ALU_SLT:    result = {{(DATA_W-1){1'b0}}, less_signed};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute slice of the 16-bit pipeline: Decode/Execute register, operand
// forwarding muxes, ALU and Execute/Memory register. Both registers capture
// on every edge; a zero control word is the bubble.
module execute_stage
    import execute_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       nop_mux_output_in,
    input  logic [DATA_W-1:0] srcA_in,
    input  logic [DATA_W-1:0] srcB_in,
    input  logic [REG_W-1:0]  rs1_decode,
    input  logic [REG_W-1:0]  rs2_decode,
    input  logic [REG_W-1:0]  rd_decode,
    input  logic [2:0]        select_forward_mux_A,
    input  logic [2:0]        select_forward_mux_B,
    input  logic [DATA_W-1:0] writeback_data,
    output logic              wre_execute,
    output logic              write_memory_enable_execute,
    output logic              load_instruction,
    output logic [1:0]        select_writeback_data_mux_execute,
    output logic [3:0]        aluOp_execute,
    output logic [REG_W-1:0]  rs1_execute,
    output logic [REG_W-1:0]  rs2_execute,
    output logic [REG_W-1:0]  rd_execute,
    output logic [DATA_W-1:0] alu_result_execute,
    output logic              wre_memory,
    output logic              write_memory_enable_memory,
    output logic [1:0]        select_writeback_data_mux_memory,
    output logic [REG_W-1:0]  rs1_memory,
    output logic [REG_W-1:0]  rs2_memory,
    output logic [REG_W-1:0]  rd_memory,
    output logic [DATA_W-1:0] alu_result_memory,
    output logic [DATA_W-1:0] srcA_memory,
    output logic [DATA_W-1:0] srcB_memory
);

    logic [DATA_W-1:0] srcA_execute;
    logic [DATA_W-1:0] srcB_execute;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              unused_ctrl_bits;

    // Upper control-word bits carry nothing this stage needs.
    assign unused_ctrl_bits = ^nop_mux_output_in[15:9];

    // Decode/Execute register: split the control word and latch operands/indices.
    always_ff @(posedge clk) begin
        if (reset) begin
            wre_execute                       <= 1'b0;
            write_memory_enable_execute       <= 1'b0;
            load_instruction                  <= 1'b0;
            select_writeback_data_mux_execute <= 2'd0;
            aluOp_execute                     <= 4'd0;
            rs1_execute                       <= '0;
            rs2_execute                       <= '0;
            rd_execute                        <= '0;
            srcA_execute                      <= '0;
            srcB_execute                      <= '0;
        end else begin
            wre_execute                       <= nop_mux_output_in[CTRL_WRE];
            write_memory_enable_execute       <= nop_mux_output_in[CTRL_WMEM];
            load_instruction                  <= nop_mux_output_in[CTRL_LOAD];
            select_writeback_data_mux_execute <= nop_mux_output_in[CTRL_SEL_WB_HI:CTRL_SEL_WB_LO];
            aluOp_execute                     <= nop_mux_output_in[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
            rs1_execute                       <= rs1_decode;
            rs2_execute                       <= rs2_decode;
            rd_execute                        <= rd_decode;
            srcA_execute                      <= srcA_in;
            srcB_execute                      <= srcB_in;
        end
    end

    // Forwarding muxes: pick register value, writeback result or our own memory-stage result.
    always_comb begin
        operand_a = srcA_execute;
        operand_b = srcB_execute;
        case (select_forward_mux_A)
            FWD_WB:  operand_a = writeback_data;
            FWD_MEM: operand_a = alu_result_memory;
            default: operand_a = srcA_execute;
        endcase
        case (select_forward_mux_B)
            FWD_WB:  operand_b = writeback_data;
            FWD_MEM: operand_b = alu_result_memory;
            default: operand_b = srcB_execute;
        endcase
    end

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .alu_op (alu_op_e'(aluOp_execute)),
        .src_a  (operand_a),
        .src_b  (operand_b),
        .result (alu_result_execute)
    );

    // Execute/Memory register: pass control and indices on, capture the result and forwarded operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            wre_memory                       <= 1'b0;
            write_memory_enable_memory       <= 1'b0;
            select_writeback_data_mux_memory <= 2'd0;
            rs1_memory                       <= '0;
            rs2_memory                       <= '0;
            rd_memory                        <= '0;
            alu_result_memory                <= '0;
            srcA_memory                      <= '0;
            srcB_memory                      <= '0;
        end else begin
            wre_memory                       <= wre_execute;
            write_memory_enable_memory       <= write_memory_enable_execute;
            select_writeback_data_mux_memory <= select_writeback_data_mux_execute;
            rs1_memory                       <= rs1_execute;
            rs2_memory                       <= rs2_execute;
            rd_memory                        <= rd_execute;
            alu_result_memory                <= alu_result_execute;
            srcA_memory                      <= operand_a;
            srcB_memory                      <= operand_b;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: each stimulus slot pushes the values it
// expects, tagged with the cycle they are due; a negedge monitor compares them.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] nop_mux_output_in;
    logic [15:0] srcA_in, srcB_in;
    logic [3:0]  rs1_decode, rs2_decode, rd_decode;
    logic [2:0]  select_forward_mux_A, select_forward_mux_B;
    logic [15:0] writeback_data;
    logic        wre_execute, write_memory_enable_execute, load_instruction;
    logic [1:0]  select_writeback_data_mux_execute;
    logic [3:0]  aluOp_execute;
    logic [3:0]  rs1_execute, rs2_execute, rd_execute;
    logic [15:0] alu_result_execute;
    logic        wre_memory, write_memory_enable_memory;
    logic [1:0]  select_writeback_data_mux_memory;
    logic [3:0]  rs1_memory, rs2_memory, rd_memory;
    logic [15:0] alu_result_memory, srcA_memory, srcB_memory;

    execute_stage dut (
        .clk                               (clk),
        .reset                             (reset),
        .nop_mux_output_in                 (nop_mux_output_in),
        .srcA_in                           (srcA_in),
        .srcB_in                           (srcB_in),
        .rs1_decode                        (rs1_decode),
        .rs2_decode                        (rs2_decode),
        .rd_decode                         (rd_decode),
        .select_forward_mux_A              (select_forward_mux_A),
        .select_forward_mux_B              (select_forward_mux_B),
        .writeback_data                    (writeback_data),
        .wre_execute                       (wre_execute),
        .write_memory_enable_execute       (write_memory_enable_execute),
        .load_instruction                  (load_instruction),
        .select_writeback_data_mux_execute (select_writeback_data_mux_execute),
        .aluOp_execute                     (aluOp_execute),
        .rs1_execute                       (rs1_execute),
        .rs2_execute                       (rs2_execute),
        .rd_execute                        (rd_execute),
        .alu_result_execute                (alu_result_execute),
        .wre_memory                        (wre_memory),
        .write_memory_enable_memory        (write_memory_enable_memory),
        .select_writeback_data_mux_memory  (select_writeback_data_mux_memory),
        .rs1_memory                        (rs1_memory),
        .rs2_memory                        (rs2_memory),
        .rd_memory                         (rd_memory),
        .alu_result_memory                 (alu_result_memory),
        .srcA_memory                       (srcA_memory),
        .srcB_memory                       (srcB_memory)
    );

    always #5 clk = ~clk;

    localparam int S_ALU_EX    = 0;
    localparam int S_WRE_EX    = 1;
    localparam int S_WMEM_EX   = 2;
    localparam int S_LOAD_EX   = 3;
    localparam int S_SELWB_EX  = 4;
    localparam int S_ALUOP_EX  = 5;
    localparam int S_RD_EX     = 6;
    localparam int S_WRE_MEM   = 7;
    localparam int S_WMEM_MEM  = 8;
    localparam int S_SELWB_MEM = 9;
    localparam int S_RS1_MEM   = 10;
    localparam int S_RS2_MEM   = 11;
    localparam int S_RD_MEM    = 12;
    localparam int S_ALU_MEM   = 13;
    localparam int S_SRCA_MEM  = 14;
    localparam int S_SRCB_MEM  = 15;

    typedef struct {
        int          due;
        int          sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t scoreboard[$];
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;
    logic [15:0] sweep_exp [16];

    // Count rising edges so expectations can be tagged with the cycle they are due.
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [15:0] getActual(input int sig);
        case (sig)
            S_ALU_EX:    return alu_result_execute;
            S_WRE_EX:    return {15'd0, wre_execute};
            S_WMEM_EX:   return {15'd0, write_memory_enable_execute};
            S_LOAD_EX:   return {15'd0, load_instruction};
            S_SELWB_EX:  return {14'd0, select_writeback_data_mux_execute};
            S_ALUOP_EX:  return {12'd0, aluOp_execute};
            S_RD_EX:     return {12'd0, rd_execute};
            S_WRE_MEM:   return {15'd0, wre_memory};
            S_WMEM_MEM:  return {15'd0, write_memory_enable_memory};
            S_SELWB_MEM: return {14'd0, select_writeback_data_mux_memory};
            S_RS1_MEM:   return {12'd0, rs1_memory};
            S_RS2_MEM:   return {12'd0, rs2_memory};
            S_RD_MEM:    return {12'd0, rd_memory};
            S_ALU_MEM:   return alu_result_memory;
            S_SRCA_MEM:  return srcA_memory;
            S_SRCB_MEM:  return srcB_memory;
            default:     return 16'hxxxx;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic pushExp(input string name, input int sig, input logic [15:0] expected, input int lat);
        exp_t e;
        e.due  = cycle + lat;
        e.sig  = sig;
        e.exp  = expected;
        e.name = name;
        scoreboard.push_back(e);
    endtask

    // Drive one slot of inputs and advance past the next rising edge.
    task automatic applyStimulus(input logic rst, input logic [15:0] ctrl,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rd,
                                 input logic [2:0] sel_a, input logic [2:0] sel_b,
                                 input logic [15:0] wb);
        reset                = rst;
        nop_mux_output_in    = ctrl;
        srcA_in              = a;
        srcB_in              = b;
        rs1_decode           = r1;
        rs2_decode           = r2;
        rd_decode            = rd;
        select_forward_mux_A = sel_a;
        select_forward_mux_B = sel_b;
        writeback_data       = wb;
        @(posedge clk);
        #1;
    endtask

    // Monitor: at each falling edge compare every expectation due this cycle.
    always @(negedge clk) begin
        for (int i = scoreboard.size() - 1; i >= 0; i--) begin
            if (scoreboard[i].due == cycle) begin
                checkOutput(scoreboard[i].name, getActual(scoreboard[i].sig), scoreboard[i].exp);
                scoreboard.delete(i);
            end
        end
    end

    initial begin
        sweep_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h8003, 16'h8003, 16'h0004, 16'h2000, 16'hE000,
                      16'h0002, 16'h8001, 16'h0002, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        // Reset with busy inputs: everything registered clears.
        pushExp("rst_alu_ex",   S_ALU_EX,   16'h0000, 1);
        pushExp("rst_wre_ex",   S_WRE_EX,   16'h0000, 1);
        pushExp("rst_wmem_ex",  S_WMEM_EX,  16'h0000, 1);
        pushExp("rst_load_ex",  S_LOAD_EX,  16'h0000, 1);
        pushExp("rst_rd_ex",    S_RD_EX,    16'h0000, 1);
        pushExp("rst_wre_mem",  S_WRE_MEM,  16'h0000, 1);
        pushExp("rst_alu_mem",  S_ALU_MEM,  16'h0000, 1);
        pushExp("rst_srca_mem", S_SRCA_MEM, 16'h0000, 1);
        pushExp("rst_srcb_mem", S_SRCB_MEM, 16'h0000, 1);
        pushExp("rst_rd_mem",   S_RD_MEM,   16'h0000, 1);
        applyStimulus(1'b1, 16'hFFFF, 16'hAAAA, 16'h5555, 4'hF, 4'hF, 4'hF, 3'd1, 3'd1, 16'h1234);

        // ADD 3+4 -> rd 2.
        $display("[TB] add pipeline");
        pushExp("add_alu_ex",    S_ALU_EX,    16'h0007, 1);
        pushExp("add_wre_ex",    S_WRE_EX,    16'h0001, 1);
        pushExp("add_rd_ex",     S_RD_EX,     16'h0002, 1);
        pushExp("add_selwb_ex",  S_SELWB_EX,  16'h0001, 1);
        pushExp("add_alu_mem",   S_ALU_MEM,   16'h0007, 2);
        pushExp("add_rd_mem",    S_RD_MEM,    16'h0002, 2);
        pushExp("add_wre_mem",   S_WRE_MEM,   16'h0001, 2);
        pushExp("add_selwb_mem", S_SELWB_MEM, 16'h0001, 2);
        pushExp("add_rs1_mem",   S_RS1_MEM,   16'h0001, 2);
        pushExp("add_rs2_mem",   S_RS2_MEM,   16'h0005, 2);
        applyStimulus(1'b0, 16'h0005, 16'h0003, 16'h0004, 4'd1, 4'd5, 4'd2, 3'd0, 3'd0, 16'h0000);

        // Producer: 0x10 lands in alu_result_memory two slots later.
        $display("[TB] forwarding");
        pushExp("fwd_prod_mem", S_ALU_MEM, 16'h0010, 2);
        applyStimulus(1'b0, 16'h0005, 16'h0010, 16'h0000, 4'd0, 4'd0, 4'd3, 3'd0, 3'd0, 16'h0000);

        // SUB whose operands come from memory stage (A) and writeback (B).
        pushExp("fwd_sub_ex",    S_ALU_EX,   16'h000A, 1);
        pushExp("fwd_aluop_ex",  S_ALUOP_EX, 16'h0001, 1);
        pushExp("fwd_sub_mem",   S_ALU_MEM,  16'h000A, 2);
        pushExp("fwd_srca_mem",  S_SRCA_MEM, 16'h0010, 2);
        pushExp("fwd_srcb_mem",  S_SRCB_MEM, 16'h0006, 2);
        applyStimulus(1'b0, 16'h0015, 16'h1111, 16'h2222, 4'd1, 4'd2, 4'd4, 3'd0, 3'd0, 16'h0000);

        // SUB 0x50-5 executed with sel_A = 7 (register fallback).
        pushExp("fwd7_sub_ex",   S_ALU_EX,   16'h004B, 1);
        pushExp("fwd7_srca_mem", S_SRCA_MEM, 16'h0050, 2);
        applyStimulus(1'b0, 16'h0015, 16'h0050, 16'h0005, 4'd2, 4'd3, 4'd5, 3'd2, 3'd1, 16'h0006);

        // Store: address and data flow to the memory stage.
        $display("[TB] store path");
        pushExp("st_wmem_ex",   S_WMEM_EX,  16'h0001, 1);
        pushExp("st_wre_ex",    S_WRE_EX,   16'h0000, 1);
        pushExp("st_srca_mem",  S_SRCA_MEM, 16'h0020, 2);
        pushExp("st_srcb_mem",  S_SRCB_MEM, 16'h1234, 2);
        pushExp("st_wmem_mem",  S_WMEM_MEM, 16'h0001, 2);
        pushExp("st_wre_mem",   S_WRE_MEM,  16'h0000, 2);
        pushExp("st_rs2_mem",   S_RS2_MEM,  16'h0007, 2);
        applyStimulus(1'b0, 16'h0002, 16'h0020, 16'h1234, 4'd6, 4'd7, 4'd0, 3'd7, 3'd0, 16'h0006);

        // ALU sweep, A=0x8001 B=0x0002; op 9 also flags a load.
        $display("[TB] alu sweep");
        for (int op = 2; op < 16; op++) begin
            logic [15:0] ctrl;
            ctrl = 16'h0001 | 16'(op << 4) | ((op == 9) ? 16'h0100 : 16'h0000);
            pushExp($sformatf("sweep_op%0d", op), S_ALU_EX, sweep_exp[op], 1);
            pushExp($sformatf("sweep_aluop%0d", op), S_ALUOP_EX, 16'(op), 1);
            if (op == 9 || op == 10)
                pushExp($sformatf("sweep_load%0d", op), S_LOAD_EX, (op == 9) ? 16'h0001 : 16'h0000, 1);
            applyStimulus(1'b0, ctrl, 16'h8001, 16'h0002, 4'd0, 4'd0, 4'd1, 3'd0, 3'd0, 16'h0000);
        end

        // Bubble: indices and operands move, enables stay low.
        $display("[TB] bubble");
        pushExp("bub_wre_ex",   S_WRE_EX,   16'h0000, 1);
        pushExp("bub_wmem_ex",  S_WMEM_EX,  16'h0000, 1);
        pushExp("bub_rd_ex",    S_RD_EX,    16'h000B, 1);
        pushExp("bub_wre_mem",  S_WRE_MEM,  16'h0000, 2);
        pushExp("bub_wmem_mem", S_WMEM_MEM, 16'h0000, 2);
        pushExp("bub_rs1_mem",  S_RS1_MEM,  16'h0009, 2);
        pushExp("bub_rs2_mem",  S_RS2_MEM,  16'h000A, 2);
        pushExp("bub_rd_mem",   S_RD_MEM,   16'h000B, 2);
        pushExp("bub_srca_mem", S_SRCA_MEM, 16'h7777, 2);
        applyStimulus(1'b0, 16'h0000, 16'h7777, 16'h0001, 4'd9, 4'd10, 4'd11, 3'd0, 3'd0, 16'h0000);

        // Mid-run reset with valid work in both stages.
        $display("[TB] mid-run reset");
        pushExp("mr_wre_ex1",  S_WRE_EX,   16'h0001, 1);
        pushExp("mr_rd_ex1",   S_RD_EX,    16'h000C, 1);
        pushExp("mr_rd_mem1",  S_RD_MEM,   16'h000C, 2);
        pushExp("mr_wmem_mem1", S_WMEM_MEM, 16'h0001, 2);
        applyStimulus(1'b0, 16'h0007, 16'h0001, 16'h0001, 4'd1, 4'd1, 4'd12, 3'd0, 3'd0, 16'h0000);
        pushExp("mr_rd_ex2",   S_RD_EX,    16'h000D, 1);
        applyStimulus(1'b0, 16'h0005, 16'h0002, 16'h0002, 4'd2, 4'd2, 4'd13, 3'd0, 3'd0, 16'h0000);
        pushExp("mr_clr_alu_ex",   S_ALU_EX,   16'h0000, 1);
        pushExp("mr_clr_wre_ex",   S_WRE_EX,   16'h0000, 1);
        pushExp("mr_clr_rd_ex",    S_RD_EX,    16'h0000, 1);
        pushExp("mr_clr_wre_mem",  S_WRE_MEM,  16'h0000, 1);
        pushExp("mr_clr_wmem_mem", S_WMEM_MEM, 16'h0000, 1);
        pushExp("mr_clr_rd_mem",   S_RD_MEM,   16'h0000, 1);
        pushExp("mr_clr_alu_mem",  S_ALU_MEM,  16'h0000, 1);
        pushExp("mr_clr_srca_mem", S_SRCA_MEM, 16'h0000, 1);
        applyStimulus(1'b1, 16'h0005, 16'h0009, 16'h0009, 4'd3, 4'd3, 4'd14, 3'd0, 3'd0, 16'h0000);

        // Idle slots, then drain whatever is still pending within a bounded time.
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0, 16'h0000);
        for (int k = 0; k < 10 && scoreboard.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        while (scoreboard.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: never compared, expected 0x%04h", scoreboard[0].name, scoreboard[0].exp);
            void'(scoreboard.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
